// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// The control word groups every per-stage control so a single NOP value can clear them all.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic freeze_if;
    logic bubble_id_exe;
    logic flush_if_id;
    logic flush_id_exe;
    logic freeze_all;
    logic mem_start;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam int DEF_RESET_HOLD  = 4;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > branch flush > hazard bubble.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   INIT     | pipeline held flushed for RESET_HOLD cycles after reset
//   RUN      | normal issue; memory, branch, hazard resolved by priority
//   MEM_WAIT | multi-cycle data access outstanding, everything frozen
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = DEF_RESET_HOLD,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_if,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_all,
  output logic             mem_start,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_set;
  logic              frozen;
  ctrl_t             ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        mem_error <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl      = CTRL_NOP;
    state_nxt = state;
    hold_nxt  = hold_cnt;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    frozen    = 1'b0;

    case (state)
      INIT: begin
        ctrl.freeze_if    = 1'b1;
        ctrl.flush_if_id  = 1'b1;
        ctrl.flush_id_exe = 1'b1;
        if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end

      RUN: begin
        if (mem_access) begin
          ctrl.mem_start = 1'b1;
          if (!mem_ready) begin
            frozen    = 1'b1;
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end
        end
        ctrl.freeze_all = frozen;
        // the branch discards the ID instruction, so its hazard is moot
        if (!frozen) begin
          if (branch_taken) begin
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_exe = 1'b1;
          end else if (hazard) begin
            ctrl.freeze_if     = 1'b1;
            ctrl.bubble_id_exe = 1'b1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          // drop the access and release the pipeline
          err_set   = 1'b1;
          state_nxt = RUN;
        end else begin
          ctrl.freeze_all = 1'b1;
          wait_nxt        = wait_cnt + WAIT_W'(1);
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign freeze_if     = ctrl.freeze_if;
  assign bubble_id_exe = ctrl.bubble_id_exe;
  assign flush_if_id   = ctrl.flush_if_id;
  assign flush_id_exe  = ctrl.flush_id_exe;
  assign freeze_all    = ctrl.freeze_all;
  assign mem_start     = ctrl.mem_start;

  logic stall_inc, flush_inc, bubble_inc;

  assign stall_inc  = (state != INIT) && (ctrl.freeze_all || ctrl.freeze_if);
  assign flush_inc  = (state == RUN) && ctrl.flush_if_id;
  assign bubble_inc = ctrl.bubble_id_exe;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .clr   (cnt_clr),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vectors, per-cycle comparison against a behavioural
// model of the stall/flush rules, plus hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int RH  = 4;
  localparam int MT  = 5;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard = 1'b0, branch_taken = 1'b0, mem_access = 1'b0;
  logic          mem_ready = 1'b0, cnt_clr = 1'b0;
  logic          freeze_if, bubble_id_exe, flush_if_id, flush_id_exe;
  logic          freeze_all, mem_start, mem_error;
  logic [CW-1:0] stall_cnt, flush_cnt, bubble_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_ctrl #(.RESET_HOLD(RH), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .mem_access    (mem_access),
    .mem_ready     (mem_ready),
    .cnt_clr       (cnt_clr),
    .freeze_if     (freeze_if),
    .bubble_id_exe (bubble_id_exe),
    .flush_if_id   (flush_if_id),
    .flush_id_exe  (flush_id_exe),
    .freeze_all    (freeze_all),
    .mem_start     (mem_start),
    .mem_error     (mem_error),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 0;
  int m_init_left, m_wait_n, m_stall, m_flush, m_bubble;
  bit m_wait, m_err;
  bit e_fif, e_bub, e_fl1, e_fl2, e_fa, e_ms, e_tmo;

  task automatic m_reset();
    m_init_left = RH;
    m_wait      = 0;
    m_wait_n    = 0;
    m_err       = 0;
    m_stall     = 0;
    m_flush     = 0;
    m_bubble    = 0;
  endtask

  function automatic int bump(input int v, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && v < SAT) return v + 1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!m_valid) begin
      if (rst) begin
        m_reset();
        m_valid = 1;
      end
    end else begin
      {e_fif, e_bub, e_fl1, e_fl2, e_fa, e_ms, e_tmo} = '0;
      if (m_init_left > 0) begin
        {e_fif, e_fl1, e_fl2} = 3'b111;
      end else if (m_wait) begin
        e_tmo = !mem_ready && (m_wait_n == MT);
        e_fa  = !mem_ready && !e_tmo;
      end else begin
        e_ms = mem_access;
        e_fa = mem_access && !mem_ready;
        if (!e_fa && branch_taken) {e_fl1, e_fl2} = 2'b11;
        else if (!e_fa && hazard) {e_fif, e_bub} = 2'b11;
      end

      chk("ctrl", {26'd0, freeze_if, bubble_id_exe, flush_if_id, flush_id_exe, freeze_all, mem_start},
          {26'd0, e_fif, e_bub, e_fl1, e_fl2, e_fa, e_ms});
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
      chk("mem_error", 32'(mem_error), 32'(m_err));

      if (rst) begin
        m_reset();
      end else begin
        m_stall  = bump(m_stall, (m_init_left == 0) && (e_fa || e_fif), cnt_clr);
        m_flush  = bump(m_flush, (m_init_left == 0) && e_fl1, cnt_clr);
        m_bubble = bump(m_bubble, e_bub, cnt_clr);
        if (m_init_left > 0) begin
          m_init_left--;
        end else if (m_wait) begin
          if (mem_ready) m_wait = 0;
          else if (e_tmo) begin
            m_err  = 1;
            m_wait = 0;
          end else m_wait_n++;
        end else if (mem_access && !mem_ready) begin
          m_wait   = 1;
          m_wait_n = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of inputs, then returns just after the following falling edge.
  task automatic drive(input logic r, input logic h, input logic b, input logic ma,
                       input logic mr, input logic cc);
    @(posedge clk);
    #1;
    rst = r; hazard = h; branch_taken = b; mem_access = ma; mem_ready = mr; cnt_clr = cc;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear();
    drive(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // reset and hold-off
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < RH; i++) begin
      drive(0, 1, 1, 1, 0, 0);
      chk("init_flush", {29'd0, freeze_if, flush_if_id, flush_id_exe}, 32'h7);
      chk("init_quiet", {29'd0, bubble_id_exe, freeze_all, mem_start}, 32'h0);
    end
    idle();
    chk("run_idle_ctrl", {26'd0, freeze_if, bubble_id_exe, flush_if_id, flush_id_exe, freeze_all, mem_start}, 0);
    chk("run_idle_cnts", {26'd0, stall_cnt, flush_cnt, bubble_cnt}, 0);

    // hazard for two cycles
    drive(0, 1, 0, 0, 0, 0);
    chk("haz1", {30'd0, freeze_if, bubble_id_exe}, 32'h3);
    drive(0, 1, 0, 0, 0, 0);
    chk("haz2", {30'd0, freeze_if, bubble_id_exe}, 32'h3);
    idle();
    chk("haz_bubble_cnt", 32'(bubble_cnt), 2);
    chk("haz_stall_cnt", 32'(stall_cnt), 2);

    // branch beats hazard
    clear();
    drive(0, 1, 1, 0, 0, 0);
    chk("br_flush", {30'd0, flush_if_id, flush_id_exe}, 32'h3);
    chk("br_no_bubble", {30'd0, bubble_id_exe, freeze_if}, 0);
    idle();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_bubble_cnt", 32'(bubble_cnt), 0);

    // single-cycle access alongside a branch
    drive(0, 0, 1, 1, 1, 0);
    chk("fast_mem", {29'd0, mem_start, freeze_all, flush_if_id}, 32'h5);

    // three-cycle memory wait with a hazard held throughout
    clear();
    drive(0, 1, 0, 1, 0, 0);
    chk("mw_start", {29'd0, mem_start, freeze_all, bubble_id_exe}, 32'h6);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 1, 0, 0);
      chk("mw_hold", {29'd0, mem_start, freeze_all, bubble_id_exe}, 32'h2);
    end
    drive(0, 1, 0, 1, 1, 0);
    chk("mw_ready", {29'd0, mem_start, freeze_all, bubble_id_exe}, 32'h0);
    drive(0, 1, 0, 0, 0, 0);
    chk("mw_after_bubble", 32'(bubble_id_exe), 1);

    // timeout
    clear();
    for (int i = 0; i < MT; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk("to_freeze", 32'(freeze_all), 1);
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("to_release", {30'd0, freeze_all, mem_error}, 32'h0);
    drive(0, 1, 0, 0, 0, 0);
    chk("to_error", 32'(mem_error), 1);
    chk("to_back_in_run", 32'(bubble_id_exe), 1);
    for (int i = 0; i < 3; i++) idle();
    chk("to_sticky", 32'(mem_error), 1);

    // reset while waiting on memory
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    chk("rst_in_wait_frozen", 32'(freeze_all), 1);
    idle();
    chk("rst_in_wait_init", {29'd0, freeze_if, freeze_all, mem_error}, 32'h4);
    for (int i = 0; i < RH; i++) idle();
    chk("rst_in_wait_run", 32'(freeze_if), 0);

    // saturation and clear
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0);
    idle();
    chk("sat_bubble", 32'(bubble_cnt), 3);
    chk("sat_stall", 32'(stall_cnt), 3);
    drive(0, 1, 0, 0, 0, 1);
    idle();
    chk("clr_wins", 32'(bubble_cnt), 0);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
